fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction fetch buffer: the consumer end of the IF1→FIFO stage handshake.
- Accepts one fetch packet per cycle (PC, next PC, two instructions, icache exception info, cookie) when fifo_readygo && fifo_allowin.
- Queues packets in a circular buffer and presents them in order to the decode stage through an allowin/readygo handshake.
- Also drives fetch_buf_full back to the IF1 stage for early throttling.

Parameters:
- DEPTH, 8, number of packet entries; power of two, ≥4.
- AFULL_TH, DEPTH-1, occupancy at or above which fetch_buf_full asserts.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; empties the buffer.
- fifo_readygo  in  1  upstream packet valid.
- fifo_allowin  out  1  buffer can accept a packet this cycle.
- fetch_buf_full  out  1  almost-full throttle to IF1.
- if1_fifo_pc  in  32  packet PC.
- if1_fifo_pc_next  in  32  predicted next PC.
- if1_fifo_inst0  in  32  first instruction.
- if1_fifo_inst1  in  32  second instruction.
- if1_fifo_icache_badv  in  32  bad virtual address.
- if1_fifo_icache_exception  in  7  exception code.
- if1_fifo_icache_excp_flag  in  2  exception-valid flags (per slot).
- if1_fifo_icache_cookie_out  in  32  predictor cookie.
- id_allowin  in  1  decode accepts head packet.
- fetch_buf_readygo  out  1  head packet valid.
- fetch_buf_pc, fetch_buf_pc_next, fetch_buf_inst0, fetch_buf_inst1, fetch_buf_badv, fetch_buf_cookie  out  32 each  head packet fields.
- fetch_buf_exception  out  7  head exception code.
- fetch_buf_excp_flag  out  2  head exception flags.
- fetch_buf_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rstn=0, asynchronous):
  - head, tail and count go to 0.
  - fifo_allowin=1, fetch_buf_readygo=0, fetch_buf_full=0.
  - Storage contents are don't-care.
  - Output fields read as PC_RESET, PC_RESET+4, INST_NOP, INST_NOP, zero, 0, 0, zero while empty.
- push = fifo_readygo && fifo_allowin. The packet is written at tail; tail increments modulo DEPTH.
- pop = fetch_buf_readygo && id_allowin. head increments modulo DEPTH.
- fifo_allowin = (count != DEPTH). It is purely occupancy-based; a same-cycle pop does not admit a push when full.
- fetch_buf_readygo = (count != 0).
- Head fields are driven combinationally from entry[head] and masked to the empty defaults when count==0.
- No empty bypass: a packet pushed in cycle N is visible at the head in cycle N+1 at the earliest.
- count update: +1 on push only, -1 on pop only, unchanged on push&&pop. Never exceeds DEPTH and never underflows.
- fetch_buf_full = (count >= AFULL_TH), registered-count based.
- flush (synchronous, highest priority):
  - head, tail and count go to 0 next cycle; any same-cycle push and pop are discarded.
  - fifo_allowin stays 1 during flush. The upstream register also clears on flush.
- Order is strictly FIFO. Packet fields are stored unmodified; excp_flag is carried bit-exact.
- Pointer wrap: after DEPTH pushes, tail returns to 0. Full and empty are distinguished by count, not by pointer equality.
- No internal FSM beyond the pointers. All state is in the head, tail and count registers plus entry storage.

Decomposition:
- Shared define header already supplies PC_RESET, INST_NOP and zero.
- Add a packet width constant, FB_PKT_W = 32*6+7+2 = 201, and field offset constants so packets are stored as one flat vector.
- One natural sub-module: fetch_buffer_ram, a DEPTH×FB_PKT_W register array with one write port and one asynchronous read port.
- Pointer and count control stays in the top module.

Test Plan:
- Reset then idle: rstn low for 2 cycles, then high, with no traffic → fifo_allowin=1, fetch_buf_readygo=0, fetch_buf_pc=PC_RESET, fetch_buf_inst0=INST_NOP, count=0.
- Single packet: push pc=0x1c000000, inst0=0x02800000, inst1=0x0280040c with id_allowin=1 → fetch_buf_readygo goes high the next cycle with the same values; popped; count returns to 0.
- Fill and full (id_allowin=0):
  - Push 8 packets with pc 0x1c000000+8k → count=8, fifo_allowin=0.
  - fetch_buf_full asserts when count reaches 7.
  - A 9th push attempt is not stored.
- Full with simultaneous pop: at count=8, id_allowin=1 and fifo_readygo=1 → pop only, count=7 next cycle, fifo_allowin=1; the next push is accepted and order is preserved across the wrap.
- Flush mid-stream: count=5 with push and pop in the same cycle as flush=1 → count=0 next cycle, readygo=0; the following push of pc=0x1c000100 is the next head.
- Exception passthrough and async reset: push exception=7'h08, excp_flag=2'b01, badv=0x1c000004 and check it appears at the head intact; then drop rstn mid-stream with count=3 → outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared constants and packet layout for the instruction fetch buffer.
// Packets are stored as one flat vector; the offsets below define the field layout.
package fetch_buffer_pkg;

  localparam logic [31:0] PC_RESET = 32'h1c00_0000;
  localparam logic [31:0] INST_NOP = 32'h0340_0000;
  localparam logic [31:0] ZERO32   = 32'h0000_0000;

  localparam int unsigned FB_PKT_W = 32 * 6 + 7 + 2;

  localparam int unsigned FB_PC_LSB      = 0;
  localparam int unsigned FB_PC_NEXT_LSB = 32;
  localparam int unsigned FB_INST0_LSB   = 64;
  localparam int unsigned FB_INST1_LSB   = 96;
  localparam int unsigned FB_BADV_LSB    = 128;
  localparam int unsigned FB_COOKIE_LSB  = 160;
  localparam int unsigned FB_EXC_LSB     = 192;
  localparam int unsigned FB_FLAG_LSB    = 199;

  function automatic logic [FB_PKT_W-1:0] fb_pack(
    input logic [31:0] pc,
    input logic [31:0] pc_next,
    input logic [31:0] inst0,
    input logic [31:0] inst1,
    input logic [31:0] badv,
    input logic [31:0] cookie,
    input logic [6:0]  exc,
    input logic [1:0]  flag
  );
    logic [FB_PKT_W-1:0] pkt;
    pkt = '0;
    pkt[FB_PC_LSB      +: 32] = pc;
    pkt[FB_PC_NEXT_LSB +: 32] = pc_next;
    pkt[FB_INST0_LSB   +: 32] = inst0;
    pkt[FB_INST1_LSB   +: 32] = inst1;
    pkt[FB_BADV_LSB    +: 32] = badv;
    pkt[FB_COOKIE_LSB  +: 32] = cookie;
    pkt[FB_EXC_LSB     +: 7]  = exc;
    pkt[FB_FLAG_LSB    +: 2]  = flag;
    return pkt;
  endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// Packet storage: register array with one synchronous write port and one
// asynchronous read port. Contents are not reset.
module fetch_buffer_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 201
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular packet queue between IF1 and decode.
// Head/tail pointers plus an occupancy count; full/empty decided by count.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AFULL_TH = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     fifo_readygo,
  output logic                     fifo_allowin,
  output logic                     fetch_buf_full,
  input  logic [31:0]              if1_fifo_pc,
  input  logic [31:0]              if1_fifo_pc_next,
  input  logic [31:0]              if1_fifo_inst0,
  input  logic [31:0]              if1_fifo_inst1,
  input  logic [31:0]              if1_fifo_icache_badv,
  input  logic [6:0]               if1_fifo_icache_exception,
  input  logic [1:0]               if1_fifo_icache_excp_flag,
  input  logic [31:0]              if1_fifo_icache_cookie_out,
  input  logic                     id_allowin,
  output logic                     fetch_buf_readygo,
  output logic [31:0]              fetch_buf_pc,
  output logic [31:0]              fetch_buf_pc_next,
  output logic [31:0]              fetch_buf_inst0,
  output logic [31:0]              fetch_buf_inst1,
  output logic [31:0]              fetch_buf_badv,
  output logic [31:0]              fetch_buf_cookie,
  output logic [6:0]               fetch_buf_exception,
  output logic [1:0]               fetch_buf_excp_flag,
  output logic [$clog2(DEPTH):0]   fetch_buf_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push, pop, empty;
  logic [FB_PKT_W-1:0] wr_pkt, rd_pkt;

  assign empty             = (count_q == '0);
  // flush forces allowin so the upstream stage never stalls on a flush cycle
  assign fifo_allowin      = flush || (count_q != CNT_W'(DEPTH));
  assign fetch_buf_readygo = !empty;
  assign fetch_buf_full    = (count_q >= CNT_W'(AFULL_TH));
  assign fetch_buf_count   = count_q;

  assign push = fifo_readygo && fifo_allowin && !flush;
  assign pop  = fetch_buf_readygo && id_allowin && !flush;

  assign wr_pkt = fb_pack(if1_fifo_pc, if1_fifo_pc_next, if1_fifo_inst0, if1_fifo_inst1,
                          if1_fifo_icache_badv, if1_fifo_icache_cookie_out,
                          if1_fifo_icache_exception, if1_fifo_icache_excp_flag);

  fetch_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (FB_PKT_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (tail_q),
    .wdata_i (wr_pkt),
    .raddr_i (head_q),
    .rdata_o (rd_pkt)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    fetch_buf_pc        = PC_RESET;
    fetch_buf_pc_next   = PC_RESET + 32'd4;
    fetch_buf_inst0     = INST_NOP;
    fetch_buf_inst1     = INST_NOP;
    fetch_buf_badv      = ZERO32;
    fetch_buf_cookie    = ZERO32;
    fetch_buf_exception = '0;
    fetch_buf_excp_flag = '0;
    if (!empty) begin
      fetch_buf_pc        = rd_pkt[FB_PC_LSB      +: 32];
      fetch_buf_pc_next   = rd_pkt[FB_PC_NEXT_LSB +: 32];
      fetch_buf_inst0     = rd_pkt[FB_INST0_LSB   +: 32];
      fetch_buf_inst1     = rd_pkt[FB_INST1_LSB   +: 32];
      fetch_buf_badv      = rd_pkt[FB_BADV_LSB    +: 32];
      fetch_buf_cookie    = rd_pkt[FB_COOKIE_LSB  +: 32];
      fetch_buf_exception = rd_pkt[FB_EXC_LSB     +: 7];
      fetch_buf_excp_flag = rd_pkt[FB_FLAG_LSB    +: 2];
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH=8, AFULL_TH=7).
module tb_fetch_buffer;

  localparam logic [31:0] EXP_PC_RESET = 32'h1c00_0000;
  localparam logic [31:0] EXP_NOP      = 32'h0340_0000;

  logic        clk = 1'b0;
  logic        rstn, flush, fifo_readygo, id_allowin;
  logic        fifo_allowin, fetch_buf_full, fetch_buf_readygo;
  logic [31:0] pc_i, pc_next_i, inst0_i, inst1_i, badv_i, cookie_i;
  logic [6:0]  exc_i;
  logic [1:0]  flag_i;
  logic [31:0] fetch_buf_pc, fetch_buf_pc_next, fetch_buf_inst0, fetch_buf_inst1;
  logic [31:0] fetch_buf_badv, fetch_buf_cookie;
  logic [6:0]  fetch_buf_exception;
  logic [1:0]  fetch_buf_excp_flag;
  logic [3:0]  fetch_buf_count;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(8), .AFULL_TH(7)) dut (
    .clk                        (clk),
    .rstn                       (rstn),
    .flush                      (flush),
    .fifo_readygo               (fifo_readygo),
    .fifo_allowin               (fifo_allowin),
    .fetch_buf_full             (fetch_buf_full),
    .if1_fifo_pc                (pc_i),
    .if1_fifo_pc_next           (pc_next_i),
    .if1_fifo_inst0             (inst0_i),
    .if1_fifo_inst1             (inst1_i),
    .if1_fifo_icache_badv       (badv_i),
    .if1_fifo_icache_exception  (exc_i),
    .if1_fifo_icache_excp_flag  (flag_i),
    .if1_fifo_icache_cookie_out (cookie_i),
    .id_allowin                 (id_allowin),
    .fetch_buf_readygo          (fetch_buf_readygo),
    .fetch_buf_pc               (fetch_buf_pc),
    .fetch_buf_pc_next          (fetch_buf_pc_next),
    .fetch_buf_inst0            (fetch_buf_inst0),
    .fetch_buf_inst1            (fetch_buf_inst1),
    .fetch_buf_badv             (fetch_buf_badv),
    .fetch_buf_cookie           (fetch_buf_cookie),
    .fetch_buf_exception        (fetch_buf_exception),
    .fetch_buf_excp_flag        (fetch_buf_excp_flag),
    .fetch_buf_count            (fetch_buf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [31:0] badv, input logic [6:0] exc, input logic [1:0] flag,
                       input logic [31:0] cookie);
    pc_i      = pc;
    pc_next_i = pc + 32'd8;
    inst0_i   = i0;
    inst1_i   = i1;
    badv_i    = badv;
    exc_i     = exc;
    flag_i    = flag;
    cookie_i  = cookie;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_readygo"}, 32'(fetch_buf_readygo), 32'd0);
    chk({tag, "_allowin"}, 32'(fifo_allowin), 32'd1);
    chk({tag, "_count"}, 32'(fetch_buf_count), 32'd0);
    chk({tag, "_full"}, 32'(fetch_buf_full), 32'd0);
    chk({tag, "_pc"}, fetch_buf_pc, EXP_PC_RESET);
    chk({tag, "_pcnext"}, fetch_buf_pc_next, EXP_PC_RESET + 32'd4);
    chk({tag, "_inst0"}, fetch_buf_inst0, EXP_NOP);
    chk({tag, "_inst1"}, fetch_buf_inst1, EXP_NOP);
    chk({tag, "_badv"}, fetch_buf_badv, 32'd0);
    chk({tag, "_exc"}, 32'(fetch_buf_exception), 32'd0);
    chk({tag, "_flag"}, 32'(fetch_buf_excp_flag), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; flush = 1'b0; fifo_readygo = 1'b0; id_allowin = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 7'h0, 2'b00, 32'h0);

    // Reset then idle
    tick(); tick();
    chk_empty("rst");
    rstn = 1'b1;
    tick();
    chk_empty("idle");

    // Single packet, no empty bypass
    drive(32'h1c00_0000, 32'h0280_0000, 32'h0280_040c, 32'h0, 7'h0, 2'b00, 32'h1234_5678);
    fifo_readygo = 1'b1; id_allowin = 1'b1;
    #1;
    chk("nobypass_readygo", 32'(fetch_buf_readygo), 32'd0);
    tick();
    fifo_readygo = 1'b0;
    chk("single_readygo", 32'(fetch_buf_readygo), 32'd1);
    chk("single_pc", fetch_buf_pc, 32'h1c00_0000);
    chk("single_pcnext", fetch_buf_pc_next, 32'h1c00_0008);
    chk("single_inst0", fetch_buf_inst0, 32'h0280_0000);
    chk("single_inst1", fetch_buf_inst1, 32'h0280_040c);
    chk("single_cookie", fetch_buf_cookie, 32'h1234_5678);
    chk("single_count", 32'(fetch_buf_count), 32'd1);
    tick();
    chk("single_pop_count", 32'(fetch_buf_count), 32'd0);
    chk("single_pop_readygo", 32'(fetch_buf_readygo), 32'd0);

    // Fill to full with decode stalled
    id_allowin = 1'b0;
    fifo_readygo = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(32'h1c00_0000 + 32'(8 * k), 32'h0280_0000 + 32'(k), 32'h0300_0000 + 32'(k),
            32'h0, 7'h0, 2'b00, 32'(k + 100));
      tick();
      chk($sformatf("fill%0d_count", k), 32'(fetch_buf_count), 32'(k + 1));
      chk($sformatf("fill%0d_full", k), 32'(fetch_buf_full), (k + 1 >= 7) ? 32'd1 : 32'd0);
    end
    chk("full_allowin", 32'(fifo_allowin), 32'd0);
    chk("full_head_pc", fetch_buf_pc, 32'h1c00_0000);
    drive(32'hdead_beef, 32'h1, 32'h2, 32'h0, 7'h0, 2'b00, 32'h0);
    tick();
    chk("ninth_count", 32'(fetch_buf_count), 32'd8);
    chk("ninth_head_pc", fetch_buf_pc, 32'h1c00_0000);

    // Full with simultaneous pop: only the pop happens
    id_allowin = 1'b1;
    tick();
    chk("fullpop_count", 32'(fetch_buf_count), 32'd7);
    chk("fullpop_allowin", 32'(fifo_allowin), 32'd1);
    chk("fullpop_full", 32'(fetch_buf_full), 32'd1);
    chk("fullpop_head_pc", fetch_buf_pc, 32'h1c00_0008);
    id_allowin = 1'b0;
    drive(32'h1c00_0040, 32'h0280_0040, 32'h0300_0040, 32'h0, 7'h0, 2'b00, 32'd200);
    tick();
    fifo_readygo = 1'b0;
    chk("wrap_push_count", 32'(fetch_buf_count), 32'd8);
    id_allowin = 1'b1;
    for (int j = 1; j < 8; j++) begin
      chk($sformatf("drain%0d_pc", j), fetch_buf_pc, 32'h1c00_0000 + 32'(8 * j));
      chk($sformatf("drain%0d_cookie", j), fetch_buf_cookie, 32'(j + 100));
      tick();
    end
    chk("drain_wrap_pc", fetch_buf_pc, 32'h1c00_0040);
    chk("drain_wrap_inst0", fetch_buf_inst0, 32'h0280_0040);
    tick();
    chk("drained_count", 32'(fetch_buf_count), 32'd0);

    // Flush mid-stream with concurrent push and pop
    id_allowin = 1'b0;
    fifo_readygo = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(32'h1c00_0080 + 32'(4 * k), 32'h0, 32'h0, 32'h0, 7'h0, 2'b00, 32'h0);
      tick();
    end
    chk("preflush_count", 32'(fetch_buf_count), 32'd5);
    drive(32'h1c00_00f0, 32'h0, 32'h0, 32'h0, 7'h0, 2'b00, 32'h0);
    flush = 1'b1; id_allowin = 1'b1;
    #1;
    chk("flush_allowin", 32'(fifo_allowin), 32'd1);
    tick();
    flush = 1'b0;
    chk("flush_count", 32'(fetch_buf_count), 32'd0);
    chk("flush_readygo", 32'(fetch_buf_readygo), 32'd0);
    chk("flush_allowin_after", 32'(fifo_allowin), 32'd1);
    id_allowin = 1'b0;
    drive(32'h1c00_0100, 32'h0280_0100, 32'h0300_0100, 32'h0, 7'h0, 2'b00, 32'h0);
    tick();
    fifo_readygo = 1'b0;
    chk("postflush_readygo", 32'(fetch_buf_readygo), 32'd1);
    chk("postflush_pc", fetch_buf_pc, 32'h1c00_0100);
    chk("postflush_count", 32'(fetch_buf_count), 32'd1);

    // Exception fields through a push&pop cycle
    fifo_readygo = 1'b1; id_allowin = 1'b1;
    drive(32'h1c00_0004, 32'h0, 32'h0, 32'h1c00_0004, 7'h08, 2'b01, 32'h0000_abcd);
    tick();
    id_allowin = 1'b0;
    chk("exc_count", 32'(fetch_buf_count), 32'd1);
    chk("exc_pc", fetch_buf_pc, 32'h1c00_0004);
    chk("exc_code", 32'(fetch_buf_exception), 32'h08);
    chk("exc_flag", 32'(fetch_buf_excp_flag), 32'h1);
    chk("exc_badv", fetch_buf_badv, 32'h1c00_0004);
    chk("exc_cookie", fetch_buf_cookie, 32'h0000_abcd);
    drive(32'h1c00_0200, 32'h0, 32'h0, 32'h0, 7'h0, 2'b10, 32'h0);
    tick();
    drive(32'h1c00_0208, 32'h0, 32'h0, 32'h0, 7'h0, 2'b11, 32'h0);
    tick();
    fifo_readygo = 1'b0;
    chk("prereset_count", 32'(fetch_buf_count), 32'd3);
    chk("prereset_readygo", 32'(fetch_buf_readygo), 32'd1);

    // Asynchronous reset between clock edges
    #2;
    rstn = 1'b0;
    #1;
    chk_empty("async_rst");
    tick();
    rstn = 1'b1;
    tick();
    chk_empty("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
